mem_arbiter: RTL and testbench

Two-port to one-port memory arbiter for the pipelined 64-bit MIPS core. It shares a single external memory port between the instruction-fetch port and the M-stage data port. It serialises the two ports' accesses through a small request/response state machine and raises per-port stall signals until each access completes. A watchdog forces completion and flags an error if memory never answers.

---
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one external memory port between instruction fetch and M-stage data accesses.
// Define MEMARB_RR_EN for round-robin arbitration; otherwise data always beats fetch.
module mem_arbiter #(
  parameter int N       = 64,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ireq,
  input  logic [31:0]   iadr,
  output logic          iack,
  output logic [31:0]   irdata,
  input  logic          dreq,
  input  logic [1:0]    dwe,
  input  logic          ddword,
  input  logic [N-1:0]  dadr,
  input  logic [N-1:0]  dwdata,
  output logic          dack,
  output logic [N-1:0]  drdata,
  output logic          istall,
  output logic          dstall,
  output logic          mreq,
  output logic [1:0]    mwe,
  output logic          mdword,
  output logic [N-1:0]  madr,
  output logic [N-1:0]  mwdata,
  input  logic [N-1:0]  mrdata,
  input  logic          mready,
  output logic          err
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_IBUSY,
    S_DBUSY,
    S_RESP
  } state_e;

  state_e         state_q, state_d;
  logic           own_d_q, own_d_d;     // 1: data port owns the access in flight
  logic [N-1:0]   adr_q, adr_d;
  logic [1:0]     we_q, we_d;
  logic           dword_q, dword_d;
  logic [N-1:0]   wdata_q, wdata_d;
  logic [N-1:0]   rsp_q, rsp_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           err_q, err_d;
  logic           pick_d;

`ifdef MEMARB_RR_EN
  logic           last_d_q, last_d_d;   // 1: data port was granted most recently

  assign pick_d = dreq & (~ireq | ~last_d_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_d_q <= 1'b0;
    else        last_d_q <= last_d_d;
  end
`else
  assign pick_d = dreq;
`endif

  // NOTE: every state register uses non-blocking assignment so all of them
  // update together from the values seen before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      own_d_q <= 1'b0;
      adr_q   <= '0;
      we_q    <= '0;
      dword_q <= 1'b0;
      wdata_q <= '0;
      rsp_q   <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      own_d_q <= own_d_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      dword_q <= dword_d;
      wdata_q <= wdata_d;
      rsp_q   <= rsp_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    own_d_d  = own_d_q;
    adr_d    = adr_q;
    we_d     = we_q;
    dword_d  = dword_q;
    wdata_d  = wdata_q;
    rsp_d    = rsp_q;
    wdog_d   = wdog_q;
    err_d    = err_q;
`ifdef MEMARB_RR_EN
    last_d_d = last_d_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (dreq || ireq) begin
          own_d_d = pick_d;
          state_d = pick_d ? S_DBUSY : S_IBUSY;
          adr_d   = pick_d ? dadr : N'(iadr);
          we_d    = pick_d ? dwe : 2'b00;
          dword_d = pick_d & ddword;
          wdata_d = pick_d ? dwdata : '0;
          wdog_d  = '0;
`ifdef MEMARB_RR_EN
          last_d_d = pick_d;
`endif
        end
      end

      S_IBUSY, S_DBUSY: begin
        if (mready) begin
          rsp_d   = mrdata;
          state_d = S_RESP;
        end else if (wdog_q == WD_MAX) begin
          // Memory never answered: complete with zero data and flag it.
          err_d   = 1'b1;
          rsp_d   = '0;
          state_d = S_RESP;
        end else begin
          wdog_d  = wdog_q + 1'b1;
        end
      end

      S_RESP:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign mreq   = (state_q == S_IBUSY) || (state_q == S_DBUSY);
  assign mwe    = we_q;
  assign mdword = dword_q;
  assign madr   = adr_q;
  assign mwdata = wdata_q;

  assign iack   = (state_q == S_RESP) && !own_d_q;
  assign dack   = (state_q == S_RESP) &&  own_d_q;
  assign irdata = rsp_q[31:0];
  assign drdata = rsp_q;
  assign err    = err_q;

  assign istall = ireq & ~iack;
  assign dstall = dreq & ~dack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level reference model checked every cycle,
// plus hand-computed latency, ordering, timeout and reset expectations.
module tb_mem_arbiter;

  localparam int N  = 64;
  localparam int TO = 4;
`ifdef MEMARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk    = 1'b0;
  logic          reset  = 1'b0;
  logic          ireq   = 1'b0;
  logic [31:0]   iadr   = '0;
  logic          dreq   = 1'b0;
  logic [1:0]    dwe    = '0;
  logic          ddword = 1'b0;
  logic [N-1:0]  dadr   = '0;
  logic [N-1:0]  dwdata = '0;
  logic [N-1:0]  mrdata = '0;
  logic          mready = 1'b0;

  logic          iack, dack, istall, dstall, mreq, mdword, err;
  logic [31:0]   irdata;
  logic [N-1:0]  drdata, madr, mwdata;
  logic [1:0]    mwe;

  mem_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .ireq(ireq), .iadr(iadr), .iack(iack), .irdata(irdata),
    .dreq(dreq), .dwe(dwe), .ddword(ddword), .dadr(dadr), .dwdata(dwdata),
    .dack(dack), .drdata(drdata),
    .istall(istall), .dstall(dstall),
    .mreq(mreq), .mwe(mwe), .mdword(mdword), .madr(madr), .mwdata(mwdata),
    .mrdata(mrdata), .mready(mready), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expire(input string name);
    n_checks++;
    n_errs++;
    $display("FAIL %s: no acknowledge within the cycle budget at %0t", name, $time);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Memory responder: answers after mem_wait BUSY cycles (negative = never),
  // and drives stray_rdy on mready whenever no request is outstanding.
  int mem_wait  = 0;
  bit stray_rdy = 1'b0;
  int busy_cnt  = 0;
  always @(posedge clk) begin
    #2;
    if (mreq) begin
      mready = (mem_wait >= 0) && (busy_cnt == mem_wait);
      busy_cnt++;
    end else begin
      busy_cnt = 0;
      mready   = stray_rdy;
    end
  end

  // Reference model: one access at a time; describes the cycle following each edge.
  typedef struct {
    bit           is_d;
    logic [63:0]  adr;
    logic [1:0]   we;
    bit           dw;
    logic [63:0]  wd;
  } acc_t;

  bit          m_busy, m_ack, m_err, m_last_d;
  acc_t        cur;
  int          elapsed;
  logic [63:0] m_data;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy   = 1'b0;
      m_ack    = 1'b0;
      m_err    = 1'b0;
      m_last_d = 1'b0;
      m_data   = '0;
      elapsed  = 0;
      cur      = '{1'b0, 64'h0, 2'b00, 1'b0, 64'h0};
    end else if (m_busy) begin
      if (mready) begin
        m_busy = 1'b0;
        m_ack  = 1'b1;
        m_data = mrdata;
      end else if (elapsed == TO + 1) begin
        m_busy = 1'b0;
        m_ack  = 1'b1;
        m_data = '0;
        m_err  = 1'b1;
      end else begin
        elapsed++;
      end
    end else if (m_ack) begin
      m_ack = 1'b0;
    end else if (dreq || ireq) begin
      bit pick;
      pick = dreq && (!ireq || !RR || !m_last_d);
      if (pick) cur = '{1'b1, dadr, dwe, ddword, dwdata};
      else      cur = '{1'b0, {32'h0, iadr}, 2'b00, 1'b0, 64'h0};
      m_last_d = pick;
      m_busy   = 1'b1;
      elapsed  = 1;
    end
  end

  int  mreq_cnt = 0;
  int  iack_cnt = 0;
  int  dack_cnt = 0;
  byte ack_log[$];

  always @(negedge clk) begin
    if (reset) begin
      check("mreq", mreq, m_busy);
      if (m_busy) begin
        check("madr", madr, cur.adr);
        check("mwe", mwe, cur.we);
        check("mdword", mdword, cur.dw);
        if (cur.is_d) check("mwdata", mwdata, cur.wd);
      end
      check("iack", iack, m_ack && !cur.is_d);
      check("dack", dack, m_ack && cur.is_d);
      if (m_ack && !cur.is_d) check("irdata", irdata, m_data[31:0]);
      if (m_ack && cur.is_d)  check("drdata", drdata, m_data);
      check("err", err, m_err);
      check("istall", istall, ireq && !(m_ack && !cur.is_d));
      check("dstall", dstall, dreq && !(m_ack && cur.is_d));
      if (mreq) mreq_cnt++;
      if (iack) begin iack_cnt++; ack_log.push_back("I"); end
      if (dack) begin dack_cnt++; ack_log.push_back("D"); end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits for the port's ack; returns one edge later, i.e. in the cycle after the ack.
  task automatic wait_ack(input bit is_d, input int budget, output int at_cyc,
                          output logic [63:0] data);
    int k = 0;
    at_cyc = -1;
    data   = 'x;
    while (k < budget && at_cyc < 0) begin
      @(negedge clk);
      if (is_d ? dack : iack) begin
        at_cyc = cyc;
        data   = is_d ? drdata : {32'h0, irdata};
      end
      k++;
    end
    if (at_cyc < 0) expire(is_d ? "dack_wait" : "iack_wait");
    @(posedge clk);
    #1;
  endtask

  // Keeps a port's request high until it has collected n acks.
  task automatic run_port(input bit is_d, input int n);
    int got = 0;
    int k   = 0;
    if (is_d) dreq = 1'b1; else ireq = 1'b1;
    while (got < n && k < 300) begin
      @(negedge clk);
      if (is_d ? dack : iack) got++;
      k++;
    end
    @(posedge clk);
    #1;
    if (is_d) dreq = 1'b0; else ireq = 1'b0;
    if (got < n) expire(is_d ? "run_d" : "run_i");
  endtask

  initial begin
    #200000;
    $display("FAIL sim_time_limit: bench did not finish");
    $fatal(1, "time limit reached");
  end

  initial begin
    int          req_cyc, ack_cyc;
    logic [63:0] data;
    string       exp_order;

    #1;
    check("rst_mreq", mreq, 0);
    check("rst_mwe", mwe, 0);
    check("rst_madr", madr, 0);
    check("rst_mwdata", mwdata, 0);
    check("rst_acks", {iack, dack, mdword, err}, 0);
    check("rst_drdata", drdata, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    tick(2);

    // Fetch: single-cycle memory, upper response bits must not reach irdata.
    mem_wait = 0;
    mrdata   = 64'hFFFF_FFFF_2002_0005;
    ireq     = 1'b1;
    iadr     = 32'h40;
    req_cyc  = cyc;
    @(negedge clk);
    check("f_mreq_k", mreq, 0);
    @(negedge clk);
    check("f_mreq_k1", mreq, 1);
    check("f_madr", madr, 64'h40);
    check("f_mwe", mwe, 2'b00);
    wait_ack(1'b0, 10, ack_cyc, data);
    ireq = 1'b0;
    check("f_latency", ack_cyc - req_cyc, 2);
    check("f_irdata", data, 64'h2002_0005);
    @(negedge clk);
    check("f_istall_after", istall, 0);
    tick(1);

    // Both ports request two accesses each.
    mrdata = 64'h0123_4567_89AB_CDEF;
    dwe    = 2'b00;
    ddword = 1'b1;
    dadr   = 64'h300;
    iadr   = 32'h44;
    ack_log.delete();
    fork
      run_port(1'b1, 2);
      run_port(1'b0, 2);
    join
    exp_order = RR ? "DIDI" : "DDII";
    check("order_len", ack_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < ack_log.size()) check($sformatf("order_%0d", i), ack_log[i], exp_order[i]);
    tick(1);

    // Store with three memory wait cycles.
    mem_wait = 3;
    dwe      = 2'b01;
    ddword   = 1'b1;
    dadr     = 64'h80;
    dwdata   = 64'h1122_3344_5566_7788;
    mrdata   = 64'h0;
    mreq_cnt = 0;
    dreq     = 1'b1;
    req_cyc  = cyc;
    wait_ack(1'b1, 20, ack_cyc, data);
    dreq = 1'b0;
    check("s_busy_cycles", mreq_cnt, 4);
    check("s_latency", ack_cyc - req_cyc, 5);
    tick(1);

    // Timeout on a read; memory never answers.
    mem_wait = -1;
    dwe      = 2'b00;
    ddword   = 1'b0;
    dadr     = 64'h100;
    mrdata   = 64'hDEAD_BEEF;
    mreq_cnt = 0;
    dreq     = 1'b1;
    req_cyc  = cyc;
    wait_ack(1'b1, 20, ack_cyc, data);
    dreq = 1'b0;
    check("t_busy_cycles", mreq_cnt, TO + 1);
    check("t_latency", ack_cyc - req_cyc, TO + 2);
    check("t_drdata", data, 64'h0);
    check("t_err", err, 1);
    mem_wait = 0;
    mrdata   = 64'h0000_0000_1234_5678;
    ireq     = 1'b1;
    iadr     = 32'h48;
    wait_ack(1'b0, 10, ack_cyc, data);
    ireq = 1'b0;
    check("t_next_irdata", data, 64'h1234_5678);
    check("t_err_sticky", err, 1);
    tick(1);

    // Stray mready in IDLE and RESP.
    stray_rdy = 1'b1;
    tick(3);
    iack_cnt = 0;
    dack_cnt = 0;
    mem_wait = 1;
    ireq     = 1'b1;
    iadr     = 32'h4C;
    wait_ack(1'b0, 10, ack_cyc, data);
    ireq = 1'b0;
    tick(3);
    stray_rdy = 1'b0;
    check("stray_iacks", iack_cnt, 1);
    check("stray_dacks", dack_cnt, 0);
    tick(1);

    // Reset in the middle of a data access.
    mem_wait = -1;
    dwe      = 2'b10;
    dadr     = 64'h200;
    dwdata   = 64'hCAFE_F00D;
    dreq     = 1'b1;
    tick(2);
    check("r_in_busy", mreq, 1);
    #2;
    reset = 1'b0;
    #1;
    check("r_mreq_async", mreq, 0);
    check("r_madr", madr, 0);
    check("r_mwdata", mwdata, 0);
    check("r_mwe", mwe, 0);
    check("r_err", err, 0);
    check("r_outs", {iack, dack, mdword}, 0);
    check("r_rdata", {irdata, drdata}, 0);
    @(negedge clk);
    check("r_no_dack", dack, 0);
    mem_wait = 0;
    mrdata   = 64'h55;
    @(posedge clk);
    #1;
    reset   = 1'b1;
    req_cyc = cyc;
    wait_ack(1'b1, 10, ack_cyc, data);
    dreq = 1'b0;
    check("r_regrant_latency", ack_cyc - req_cyc, 2);
    check("r_regrant_data", data, 64'h55);
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
